// File: rtl/tag_free_list.sv
// Physical-tag free list: circular buffer of free tags with speculative read,
// committed read and write pointers; rewinds speculative reads on mispredict.
module tag_free_list #(
  parameter  int unsigned NUM_ISSUE  = 3,
  parameter  int unsigned NUM_COMMIT = 3,
  parameter  int unsigned NUM_REGS   = 64,
  parameter  int unsigned NUM_TAGS   = 128,
  localparam int unsigned TAG_SIZE   = $clog2(NUM_TAGS),
  localparam int unsigned DEPTH      = NUM_TAGS - NUM_REGS,
  localparam int unsigned IW         = $clog2(DEPTH),
  localparam int unsigned PW         = IW + 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 IN_mispred,
  input  logic [NUM_ISSUE-1:0]                 IN_issueValid,
  output logic [NUM_ISSUE-1:0][TAG_SIZE-1:0]   OUT_issueTags,
  output logic                                 OUT_allocReady,
  input  logic [NUM_COMMIT-1:0]                IN_commitValid,
  input  logic [NUM_COMMIT-1:0][TAG_SIZE-1:0]  IN_commitPrevTags,
  output logic [PW-1:0]                        OUT_freeCount,
  output logic                                 OUT_error
);

  logic [DEPTH-1:0][TAG_SIZE-1:0] r_fl;
  logic [PW-1:0]                  r_spec_rd;
  logic [PW-1:0]                  r_com_rd;
  logic [PW-1:0]                  r_wr;
  logic                           r_error;

  logic [PW-1:0]                  w_free;
  logic [PW-1:0]                  w_iss_cnt;
  logic [PW-1:0]                  w_rd_ptr;
  logic [PW-1:0]                  w_grant_cnt;
  logic                           w_issue_err;
  logic [PW-1:0]                  w_cm_cnt;
  logic [NUM_COMMIT-1:0]          w_we;
  logic [NUM_COMMIT-1:0][PW-1:0]  w_waddr;
  logic                           w_drop_err;
  logic [PW-1:0]                  w_spec_rd_nxt;

  assign w_free         = r_wr - r_spec_rd;
  assign OUT_freeCount  = w_free;
  assign OUT_allocReady = (w_free >= PW'(NUM_ISSUE));
  assign OUT_error      = r_error;

  // Lookahead tags for every slot; grants are limited to entries already in the buffer.
  always_comb begin
    w_iss_cnt     = '0;
    w_rd_ptr      = '0;
    w_grant_cnt   = '0;
    OUT_issueTags = '0;
    for (int i = 0; i < int'(NUM_ISSUE); i++) begin
      w_rd_ptr         = r_spec_rd + w_iss_cnt;
      OUT_issueTags[i] = r_fl[w_rd_ptr[IW-1:0]];
      if (IN_issueValid[i]) begin
        if (w_iss_cnt < w_free) begin
          w_grant_cnt = w_grant_cnt + PW'(1);
        end
        w_iss_cnt = w_iss_cnt + PW'(1);
      end
    end
    w_issue_err = (|IN_issueValid) && !OUT_allocReady && !IN_mispred;
  end

  // Reclaim slots pack in slot order; a reclaim that would overfill the buffer is dropped.
  always_comb begin
    w_cm_cnt   = '0;
    w_we       = '0;
    w_waddr    = '0;
    w_drop_err = 1'b0;
    for (int k = 0; k < int'(NUM_COMMIT); k++) begin
      if (IN_commitValid[k]) begin
        if ((w_free + w_cm_cnt) < PW'(DEPTH)) begin
          w_we[k]    = 1'b1;
          w_waddr[k] = r_wr + w_cm_cnt;
          w_cm_cnt   = w_cm_cnt + PW'(1);
        end else begin
          w_drop_err = 1'b1;
        end
      end
    end
  end

  assign w_spec_rd_nxt = IN_mispred ? (r_com_rd + w_cm_cnt) : (r_spec_rd + w_grant_cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        r_fl[k] <= TAG_SIZE'(int'(NUM_REGS) + k);
      end
      r_spec_rd <= '0;
      r_com_rd  <= '0;
      r_wr      <= PW'(DEPTH);
      r_error   <= 1'b0;
    end else begin
      for (int k = 0; k < int'(NUM_COMMIT); k++) begin
        if (w_we[k]) begin
          r_fl[w_waddr[k][IW-1:0]] <= IN_commitPrevTags[k];
        end
      end
      r_spec_rd <= w_spec_rd_nxt;
      r_com_rd  <= r_com_rd + w_cm_cnt;
      r_wr      <= r_wr + w_cm_cnt;
      r_error   <= r_error | w_issue_err | w_drop_err;
    end
  end

endmodule

// File: tb/tb_tag_free_list.sv
// Scoreboarded bench for tag_free_list against a queue-based free-pool model.
module tb_tag_free_list;
  localparam int NI = 3, NC = 3, TW = 7, PW = 7, DEPTH = 64;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   IN_mispred = 1'b0;
  logic [NI-1:0]          IN_issueValid = '0;
  logic [NI-1:0][TW-1:0]  OUT_issueTags;
  logic                   OUT_allocReady;
  logic [NC-1:0]          IN_commitValid = '0;
  logic [NC-1:0][TW-1:0]  IN_commitPrevTags = '0;
  logic [PW-1:0]          OUT_freeCount;
  logic                   OUT_error;

  tag_free_list dut (
    .clk(clk), .rst(rst), .IN_mispred(IN_mispred), .IN_issueValid(IN_issueValid),
    .OUT_issueTags(OUT_issueTags), .OUT_allocReady(OUT_allocReady),
    .IN_commitValid(IN_commitValid), .IN_commitPrevTags(IN_commitPrevTags),
    .OUT_freeCount(OUT_freeCount), .OUT_error(OUT_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NI-1:0][TW-1:0] tags;
    logic [NI-1:0]         gmask;
    logic [PW-1:0]         free;
    logic                  ready;
    logic                  err;
    logic [127:0]          live;
    string                 name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Model: pool holds free tags in hand-out order (head = oldest), the first
  // 'taken' of them are speculatively in flight; owned = tags held by the RAT.
  int pool[$];
  int owned[$];
  int taken;
  bit m_err;

  function automatic void model_reset();
    pool = {};
    owned = {};
    for (int k = 0; k < DEPTH; k++) pool.push_back(64 + k);
    for (int k = 0; k < 64; k++) owned.push_back(k);
    taken = 0;
    m_err = 1'b0;
  endfunction

  function automatic exp_t make_exp(input logic mp, input logic [NI-1:0] iv,
                                    input string nm, output int g);
    exp_t e;
    int free, c;
    free    = DEPTH - taken;
    e.free  = PW'(free);
    e.ready = (free >= NI);
    e.err   = m_err;
    e.name  = nm;
    e.live  = '0;
    e.gmask = '0;
    foreach (owned[j]) e.live[owned[j]] = 1'b1;
    for (int j = 0; j < taken; j++) e.live[pool[j]] = 1'b1;
    c = 0;
    g = 0;
    for (int i = 0; i < NI; i++) begin
      e.tags[i] = TW'(pool[(taken + c) % DEPTH]);
      if (iv[i]) begin
        if (!mp && c < free) begin
          e.gmask[i] = 1'b1;
          g++;
        end
        c++;
      end
    end
    return e;
  endfunction

  task automatic cycle(input logic mp, input logic [NI-1:0] iv, input logic [NC-1:0] cv,
                       input logic [NC-1:0][TW-1:0] ct, input string nm);
    exp_t e;
    int g, acc, t0, idx;
    @(negedge clk);
    rst = 1'b1;
    IN_mispred = mp;
    IN_issueValid = iv;
    IN_commitValid = cv;
    IN_commitPrevTags = ct;
    e = make_exp(mp, iv, nm, g);
    sb.push_back(e);
    if (!mp && iv != '0 && (DEPTH - taken) < NI) m_err = 1'b1;
    t0 = taken;
    acc = 0;
    for (int k = 0; k < NC; k++) begin
      if (cv[k]) begin
        if (acc < t0) begin
          owned.push_back(pool.pop_front());
          idx = -1;
          foreach (owned[j]) if (owned[j] == int'(ct[k])) idx = j;
          if (idx >= 0) owned.delete(idx);
          pool.push_back(int'(ct[k]));
          acc++;
        end else begin
          m_err = 1'b1;
        end
      end
    end
    taken = mp ? 0 : (t0 - acc + g);
  endtask

  task automatic do_reset(input string nm);
    exp_t e;
    int g;
    @(negedge clk);
    rst = 1'b0;
    IN_mispred = 1'b0;
    IN_issueValid = '0;
    IN_commitValid = '0;
    IN_commitPrevTags = '0;
    model_reset();
    e = make_exp(1'b0, '0, nm, g);
    sb.push_back(e);
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs against each queued expectation mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int i = 0; i < NI; i++) begin
          check($sformatf("%s tag%0d", e.name, i), 128'(OUT_issueTags[i]), 128'(e.tags[i]));
          if (e.gmask[i]) begin
            total++;
            if (e.live[OUT_issueTags[i]]) begin
              bad++;
              $display("FAIL %s live_grant%0d: got tag %0d which is still live, want a free tag",
                       e.name, i, OUT_issueTags[i]);
            end
          end
        end
        check({e.name, " freeCount"}, 128'(OUT_freeCount), 128'(e.free));
        check({e.name, " allocReady"}, 128'(OUT_allocReady), 128'(e.ready));
        check({e.name, " error"}, 128'(OUT_error), 128'(e.err));
      end
    end
  end

  initial begin
    logic [NC-1:0][TW-1:0] ct;
    logic [NC-1:0][TW-1:0] z;
    logic [NC-1:0]         cv;
    logic [NI-1:0]         iv;
    int tmp[$];
    int lim, cnt, idx;
    z = '0;

    // Issue 3 per cycle until one entry left, then over-request.
    do_reset("t1_reset");
    for (int n = 0; n < 21; n++) cycle(1'b0, 3'b111, '0, z, $sformatf("t2_iss%0d", n));
    cycle(1'b0, 3'b111, '0, z, "t2_over");
    cycle(1'b0, 3'b000, '0, z, "t2_after");

    // Sparse valid pattern.
    do_reset("t3_reset");
    cycle(1'b0, 3'b101, '0, z, "t3_101");
    cycle(1'b0, 3'b000, '0, z, "t3_after");

    // Allocate 9, commit 3, then mispredict.
    do_reset("t4_reset");
    for (int n = 0; n < 3; n++) cycle(1'b0, 3'b111, '0, z, $sformatf("t4_iss%0d", n));
    ct = '0; ct[0] = 7'd0; ct[1] = 7'd1; ct[2] = 7'd2;
    cycle(1'b0, 3'b000, 3'b111, ct, "t4_commit");
    cycle(1'b1, 3'b000, '0, z, "t4_mispred");
    cycle(1'b0, 3'b000, '0, z, "t4_after");

    // Mispredict together with a single commit and an ignored issue.
    do_reset("t5_reset");
    cycle(1'b0, 3'b111, '0, z, "t5_iss0");
    cycle(1'b0, 3'b111, '0, z, "t5_iss1");
    ct = '0; ct[0] = 7'd5;
    cycle(1'b1, 3'b111, 3'b001, ct, "t5_mp_commit");
    cycle(1'b0, 3'b000, '0, z, "t5_after");

    // Random issue/commit/mispredict with a mid-run reset.
    do_reset("t6_reset");
    for (int n = 0; n < 200; n++) begin
      if (n == 120) do_reset("t6_midreset");
      iv = ((DEPTH - taken) >= NI) ? NI'($urandom_range(0, 7)) : '0;
      lim = (taken < NC) ? taken : NC;
      tmp = owned;
      cnt = 0;
      cv = '0;
      ct = '0;
      for (int k = 0; k < NC; k++) begin
        if ($urandom_range(0, 1) == 1 && cnt < lim) begin
          idx = $urandom_range(0, tmp.size() - 1);
          ct[k] = TW'(tmp[idx]);
          tmp.delete(idx);
          cv[k] = 1'b1;
          cnt++;
        end
      end
      cycle(($urandom_range(0, 19) == 0), iv, cv, ct, $sformatf("t6_c%0d", n));
    end
    cycle(1'b0, 3'b000, '0, z, "t6_end");

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
    #5;
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
